// File: rtl/tjmono2_rx_pkg.sv
// Shared definitions for the TJ-Monopix2 receiver word filter.
//   Word layout : [31:28] identifier, [27] error/flag bit, [26:0] payload
//   Counter width for the pass/drop statistics
//   FSM state encoding for the pop controller
package tjmono2_rx_pkg;

  localparam int WORD_W    = 32;
  localparam int PAYLOAD_W = 27;
  localparam int ID_W      = 4;
  localparam int ID_HI     = 31;
  localparam int ID_LO     = 28;
  localparam int ERR_BIT   = 27;
  localparam int CNT_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Saturating increment: holds at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/tjmono2_rx_fwft_buf.sv
// Circular first-word-fall-through buffer with a registered head word.
// Ports:
//   FIFO_CLK, RST_N : clock, asynchronous active-low reset
//   wr_en, wr_data  : write strobe and word
//   rd_en           : pop strobe (ignored while empty)
//   empty           : buffer empty
//   rd_data         : registered head word (valid while empty=0)
//   occ             : current occupancy, 0..DEPTH
module tjmono2_rx_fwft_buf
  import tjmono2_rx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = WORD_W
) (
  input  logic                       FIFO_CLK,
  input  logic                       RST_N,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic                       empty,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     occ
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_nxt;
  logic [AW:0]   occ_q;
  logic [W-1:0]  head_q;
  logic          full;
  logic          do_rd;
  logic          do_wr;

  assign empty      = (occ_q == '0);
  assign full       = (occ_q == DEPTH_C);
  assign do_rd      = rd_en & ~empty;
  // A write into a full buffer is only legal when a pop frees the slot in the same cycle.
  assign do_wr      = wr_en & (~full | do_rd);
  assign rd_ptr_nxt = rd_ptr + 1'b1;

  always_ff @(posedge FIFO_CLK) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge FIFO_CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
      head_q <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr_nxt;
      case ({do_wr, do_rd})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
      // Head register: after a pop the next entry is either already stored,
      // or (with only one entry left) is the word being written right now.
      if (do_rd) begin
        if (occ_q > (AW+1)'(1)) head_q <= mem[rd_ptr_nxt];
        else if (do_wr)         head_q <= wr_data;
      end else if (do_wr && empty) begin
        head_q <= wr_data;
      end
    end
  end

  assign rd_data = head_q;
  assign occ     = occ_q;

endmodule

// File: rtl/tjmono2_rx_word_filter.sv
// Filter stage between the TJ-Monopix2 receiver FWFT FIFO and the readout arbiter.
// Pops words, flags identifier errors, drops idle words matching DROP_PATTERN and
// re-buffers survivors behind an identical FWFT port.
// Ports:
//   FIFO_CLK, RST_N          : clock, asynchronous active-low reset
//   ENABLE                   : 1 = pop input, 0 = stop popping and drain
//   DROP_EN, DROP_PATTERN    : idle-word drop control and payload pattern
//   CNT_CLR                  : synchronous clear of counters and ID_ERR
//   IN_EMPTY, IN_DATA        : receiver FIFO status and head word
//   IN_READ                  : pop strobe to receiver FIFO
//   OUT_READ                 : pop strobe from downstream
//   OUT_EMPTY, OUT_DATA      : output buffer status and head word
//   PASS_CNT, DROP_CNT       : saturating forwarded/dropped word counters
//   ID_ERR                   : sticky identifier/flag-bit error
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | not popping, pipeline empty
// ST_RUN   | popping whenever input has data and buffer credit allows
// ST_DRAIN | stopped popping, waiting for the S1 word to reach S2
module tjmono2_rx_word_filter
  import tjmono2_rx_pkg::*;
#(
  parameter logic [ID_W-1:0] DATA_IDENTIFIER = 4'd0,
  parameter int              OBUF_DEPTH      = 4
) (
  input  logic                 FIFO_CLK,
  input  logic                 RST_N,
  input  logic                 ENABLE,
  input  logic                 DROP_EN,
  input  logic [PAYLOAD_W-1:0] DROP_PATTERN,
  input  logic                 CNT_CLR,
  input  logic                 IN_EMPTY,
  input  logic [WORD_W-1:0]    IN_DATA,
  output logic                 IN_READ,
  input  logic                 OUT_READ,
  output logic                 OUT_EMPTY,
  output logic [WORD_W-1:0]    OUT_DATA,
  output logic [CNT_W-1:0]     PASS_CNT,
  output logic [CNT_W-1:0]     DROP_CNT,
  output logic                 ID_ERR
);

  localparam int OCC_W = $clog2(OBUF_DEPTH) + 1;
  localparam logic [OCC_W:0] DEPTH_C = (OCC_W+1)'(OBUF_DEPTH);

  state_t             state_q;
  state_t             state_nxt;
  logic               pop_allow;
  logic               s1_valid;
  logic [WORD_W-1:0]  s1_word;
  logic [OCC_W-1:0]   occ;
  logic [OCC_W:0]     committed;
  logic               credit_ok;
  logic               id_bad;
  logic               is_idle;
  logic               do_fwd;
  logic               do_drop;
  logic [CNT_W-1:0]   pass_q;
  logic [CNT_W-1:0]   drop_q;
  logic               id_err_q;

  // FSM state register
  always_ff @(posedge FIFO_CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  if (ENABLE) state_nxt = ST_RUN;
      ST_RUN:   if (!ENABLE) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (ENABLE)                     state_nxt = ST_RUN;
        else if (!s1_valid && !IN_READ) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    pop_allow = 1'b0;
    case (state_q)
      ST_RUN:  pop_allow = 1'b1;
      default: pop_allow = 1'b0;
    endcase
  end

  // Reserve a buffer slot for the S1 word and for the word popped now. The S1
  // word may still be dropped, so this is conservative and never overflows.
  assign committed = {1'b0, occ} + {{OCC_W{1'b0}}, s1_valid};
  assign credit_ok = (committed < DEPTH_C);
  assign IN_READ   = pop_allow & ~IN_EMPTY & credit_ok;

  always_ff @(posedge FIFO_CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid <= 1'b0;
      s1_word  <= '0;
    end else begin
      s1_valid <= IN_READ;
      if (IN_READ) s1_word <= IN_DATA;
    end
  end

  // Identifier errors take priority: a bad word is forwarded even if its payload matches.
  assign id_bad  = (s1_word[ID_HI:ID_LO] != DATA_IDENTIFIER) | s1_word[ERR_BIT];
  assign is_idle = DROP_EN & (s1_word[PAYLOAD_W-1:0] == DROP_PATTERN);
  assign do_fwd  = s1_valid & (id_bad | ~is_idle);
  assign do_drop = s1_valid & ~id_bad & is_idle;

  always_ff @(posedge FIFO_CLK or negedge RST_N) begin
    if (!RST_N) begin
      pass_q   <= '0;
      drop_q   <= '0;
      id_err_q <= 1'b0;
    end else if (CNT_CLR) begin
      pass_q   <= '0;
      drop_q   <= '0;
      id_err_q <= 1'b0;
    end else begin
      if (do_fwd)            pass_q   <= sat_inc(pass_q);
      if (do_drop)           drop_q   <= sat_inc(drop_q);
      if (s1_valid && id_bad) id_err_q <= 1'b1;
    end
  end

  tjmono2_rx_fwft_buf #(
    .DEPTH (OBUF_DEPTH),
    .W     (WORD_W)
  ) u_obuf (
    .FIFO_CLK (FIFO_CLK),
    .RST_N    (RST_N),
    .wr_en    (do_fwd),
    .wr_data  (s1_word),
    .rd_en    (OUT_READ),
    .empty    (OUT_EMPTY),
    .rd_data  (OUT_DATA),
    .occ      (occ)
  );

  assign PASS_CNT = pass_q;
  assign DROP_CNT = drop_q;
  assign ID_ERR   = id_err_q;

endmodule
